// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA/XGA raster timing generator.
// Ports: pclk, rst (async active-low), en (advance), restart (sync to 0,0).
//   Outputs: hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_param #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 11
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Totals that do not fit the counters would silently alias.
  if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_cw
    $error("vga_timing_param: H_TOTAL/V_TOTAL exceed 2**CW");
  end

  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_hblnk;
  logic          r_vblnk;
  logic          r_de;
  logic          r_line_start;
  logic          r_frame_start;
  logic          r_restart_d;

  logic          w_h_last;
  logic          w_v_last;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic [CW-1:0] w_h_sel;
  logic [CW-1:0] w_v_sel;
  logic          w_load;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_hb;
  logic          w_vb;
  logic          w_ls;
  logic          w_fs;
  logic          w_rs_first;

  assign w_h_last = (r_hcount == H_LAST);
  assign w_v_last = (r_vcount == V_LAST);
  assign w_h_next = w_h_last ? '0 : r_hcount + 1'b1;
  assign w_v_next = !w_h_last ? r_vcount :
                    (w_v_last ? '0 : r_vcount + 1'b1);

  // Restart wins over en; the selected value feeds both counters
  // and flags so they change together.
  assign w_load  = restart | en;
  assign w_h_sel = restart ? '0 : w_h_next;
  assign w_v_sel = restart ? '0 : w_v_next;

  assign w_hs_act = (w_h_sel >= HS_BEG) && (w_h_sel <= HS_END);
  assign w_vs_act = (w_v_sel >= VS_BEG) && (w_v_sel <= VS_END);
  assign w_hb     = (w_h_sel >= H_ACT);
  assign w_vb     = (w_v_sel >= V_ACT);

  // A held restart only strobes on its first cycle.
  assign w_rs_first = restart & ~r_restart_d;
  assign w_ls = restart ? w_rs_first : (en & w_h_last);
  assign w_fs = restart ? w_rs_first : (en & w_h_last & w_v_last);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_hblnk       <= 1'b0;
      r_vblnk       <= 1'b0;
      r_de          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_restart_d   <= 1'b0;
    end else begin
      r_restart_d   <= restart;
      r_line_start  <= w_ls;
      r_frame_start <= w_fs;
      if (w_load) begin
        r_hcount <= w_h_sel;
        r_vcount <= w_v_sel;
        r_hsync  <= w_hs_act ? HS_POL : ~HS_POL;
        r_vsync  <= w_vs_act ? VS_POL : ~VS_POL;
        r_hblnk  <= w_hb;
        r_vblnk  <= w_vb;
        r_de     <= ~w_hb & ~w_vb;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
    end else if (w_fs) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign de          = r_de;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_param.sv
// tb_vga_timing_param: scoreboard bench for vga_timing_param.
// Small mode (32x17 total, CW=5) so whole frames fit in a short run.
module tb_vga_timing_param;

  localparam int   HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int   VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int   CW = 5;
  localparam logic HSP = 1'b1;
  localparam logic VSP = 1'b0;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   FT = HT * VT;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          hs;
    logic          vs;
    logic          hb;
    logic          vb;
    logic          de;
    logic          ls;
    logic          fs;
    logic [15:0]   fc;
  } obs_t;

  logic          pclk;
  logic          rst;
  logic          en;
  logic          restart;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          hblnk;
  logic          vblnk;
  logic          de;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  vga_timing_param #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .CW(CW)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .en(en),
    .restart(restart),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .vsync(vsync),
    .hblnk(hblnk),
    .vblnk(vblnk),
    .de(de),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  obs_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: linear pixel index within the frame.
  int m_p  = 0;
  bit m_ls = 0;
  bit m_fs = 0;
  bit m_rp = 0;
  int m_fc = 0;

  function automatic obs_t model_obs();
    obs_t o;
    int h;
    int v;
    h = m_p % HT;
    v = m_p / HT;
    o.h  = CW'(h);
    o.v  = CW'(v);
    o.hs = (h >= HA + HF && h < HA + HF + HS) ? HSP : ~HSP;
    o.vs = (v >= VA + VF && v < VA + VF + VS) ? VSP : ~VSP;
    o.hb = (h >= HA);
    o.vb = (v >= VA);
    o.de = (h < HA) && (v < VA);
    o.ls = m_ls;
    o.fs = m_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = 16'(m_fc);
`else
    o.fc = 16'd0;
`endif
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.h  = hcount;
    o.v  = vcount;
    o.hs = hsync;
    o.vs = vsync;
    o.hb = hblnk;
    o.vb = vblnk;
    o.de = de;
    o.ls = line_start;
    o.fs = frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fc = frame_cnt;
`else
    o.fc = 16'd0;
`endif
    return o;
  endfunction

  task automatic check(input string nm, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0d got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b fc=%0d need h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b ls=%b fs=%b fc=%0d",
        nm, cyc, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.de, a.ls, a.fs, a.fc,
        e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.de, e.ls, e.fs, e.fc);
    end
  endtask

  // Monitor: every cycle with an outstanding expectation is compared.
  initial begin
    forever begin
      @(posedge pclk);
      #1;
      cyc++;
      if (q.size() != 0) check("cycle", dut_obs(), q.pop_front());
    end
  end

  task automatic step(input bit e, input bit r);
    @(negedge pclk);
    rst = 1'b1;
    en = e;
    restart = r;
    if (r) begin
      m_p  = 0;
      m_ls = !m_rp;
      m_fs = !m_rp;
    end else if (e) begin
      m_p  = (m_p + 1) % FT;
      m_ls = (m_p % HT == 0);
      m_fs = (m_p == 0);
    end else begin
      m_ls = 0;
      m_fs = 0;
    end
    if (m_fs) m_fc = (m_fc + 1) % 65536;
    m_rp = r;
    q.push_back(model_obs());
  endtask

  task automatic do_reset(input int n);
    @(negedge pclk);
    rst = 1'b0;
    en = 1'($urandom_range(0, 1));
    restart = 1'b0;
    m_p = 0; m_ls = 0; m_fs = 0; m_rp = 0; m_fc = 0;
    #1;
    check("async_rst", dut_obs(), model_obs());
    q.push_back(model_obs());
    for (int i = 1; i < n; i++) begin
      @(negedge pclk);
      en = 1'($urandom_range(0, 1));
      q.push_back(model_obs());
    end
  endtask

  task automatic go_to(input int h, input int v);
    int k;
    k = 0;
    while (!((m_p % HT == h) && (m_p / HT == v)) && k <= FT) begin
      step(1'b1, 1'b0);
      k++;
    end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    restart = 1'b0;
    do_reset(3);
    // One full frame plus a line: wraps, strobes, blanking, syncs.
    repeat (FT + HT) step(1'b1, 1'b0);
    // Stall just before horizontal blanking.
    go_to(HA - 1, 2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // Restart held for three cycles, then resume.
    go_to(11, 7);
    repeat (3) step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    // Restart while stalled.
    go_to(5, 4);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    // Async reset while both syncs are active.
    go_to(HA + HF + 1, VA + VF + 1);
    do_reset(2);
    repeat (4) step(1'b1, 1'b0);
    // Randomised en/restart traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        int n;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) step(1'($urandom_range(0, 1)), 1'b1);
      end else begin
        step($urandom_range(0, 3) != 0, 1'b0);
      end
    end
    // Clean frames to end with guaranteed wraps.
    repeat (2 * FT + 3) step(1'b1, 1'b0);
    @(negedge pclk);
    en = 1'b0;
    repeat (3) @(posedge pclk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d need=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_param.md
Name: vga_timing_param

Overview:
- Parametrised successor to the fixed XGA timing generator at the head of the VGA pipeline.
- Generates hcount/vcount, sync, blanking, data-enable and frame/line strobes for any mode set by parameters. Defaults are XGA 1024x768 at the 65 MHz pclk.
- Adds a pixel clock-enable for stalling, a synchronous restart, and selectable sync polarity.
- Feeds draw_background and the downstream overlay stages unchanged.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels); line total = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); frame total = 806
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- pclk  in  1  pixel clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- en  in  1  pixel advance enable; when low, all outputs hold
- restart  in  1  synchronous restart to (0,0)
- hcount  out  CW  horizontal position, 0..H_TOTAL-1
- vcount  out  CW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level set by HS_POL
- vsync  out  1  vertical sync, level set by VS_POL
- hblnk  out  1  high when hcount >= H_ACTIVE
- vblnk  out  1  high when vcount >= V_ACTIVE
- de  out  1  ~hblnk & ~vblnk
- line_start  out  1  one-cycle strobe when hcount becomes 0
- frame_start  out  1  one-cycle strobe when (hcount,vcount) becomes (0,0)

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- All outputs are registered. Flags are computed from the next count value, so flags and counts change in the same cycle (zero relative skew).
- Reset (rst=0, async), held until rst rises:
  - hcount = 0, vcount = 0
  - hblnk = 0, vblnk = 0, de = 1
  - hsync = ~HS_POL, vsync = ~VS_POL
  - line_start = 0, frame_start = 0
- After reset, the first en cycle advances hcount to 1. No strobes are issued for the initial (0,0).
- Advance on en=1:
  - hcount increments.
  - At hcount = H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount = V_TOTAL-1 together with the hcount wrap, vcount wraps to 0.
- en=0: counters and all level outputs hold. Strobes drop to 0 after one cycle and are never re-issued while stalled.
- hsync is active (=HS_POL) while H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1.
- vsync is active (=VS_POL) while V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1. vsync changes in the same cycle as vcount.
- line_start = 1 in the cycle hcount shows 0 after a wrap.
- frame_start = 1 only when both counters show 0 after a wrap; line_start is also 1 in that cycle.
- restart=1:
  - Next cycle shows (0,0) with reset-level flags, regardless of en.
  - frame_start and line_start both pulse in that cycle.
  - restart has priority over en.
  - restart held for several cycles: counts stay at (0,0) and the strobes pulse only on the first cycle.
- Reset mid-frame returns immediately to the reset state; no strobe on release.
- Width rule: counter compares are unsigned at CW bits. Parameter combinations exceeding 2^CW are illegal; a simulation-time check reports an error.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt [15:0], reset to 0.
  - Increments in every cycle frame_start=1, including restart pulses.
  - Wraps 65535 -> 0.
  - Holds while en=0.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then en=1 with defaults for 1344 cycles -> hcount runs 0..1343 then 0, vcount=1. hsync low exactly for hcount 1048..1183. hblnk high for 1024..1343. line_start high once at the wrap.
- Full frame of 1,083,264 en cycles -> vcount wraps 805->0 with frame_start=1 once. vsync low for vcount 771..776. vblnk high for 768..805.
- en toggled 1,0,0,1 around hcount 1023 -> hcount holds 1023 for two cycles, then 1024 with hblnk=1 and de=0 in the same cycle.
- restart asserted at (500,300) for 3 cycles -> (0,0) the next cycle, frame_start and line_start=1 once only, hsync/vsync inactive.
- rst dropped at (1100,772) -> outputs at reset values immediately (async). After release, no strobe, and the first advance gives hcount=1.
- Override HS_POL=1, VS_POL=1, 640x480 (16/96/48, 10/2/33) -> hsync high for 656..751, vsync high for 490..491, line total 800. With VGA_TIMING_FRAME_CNT_EN defined, frame_cnt=3 after 3 frame wraps.
